// File: rtl/mio_bus_ctrl_pkg.sv
// Shared constants for the MIO bus controller: FSM encodings,
// slot tag width and the default slot tag map.
package mio_bus_ctrl_pkg;

    localparam int TAG_W = 4;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_RESP   = 2'd2;

    localparam logic [TAG_W-1:0] TAG_RAM   = 4'h0;
    localparam logic [TAG_W-1:0] TAG_GPIOE = 4'hE;
    localparam logic [TAG_W-1:0] TAG_GPIOF = 4'hF;

    // Slot 1 (counter) sits at tag 1; packed as slot3..slot0.
    localparam logic [4*TAG_W-1:0] DEF_SLV_TAGS =
        {TAG_GPIOF, TAG_GPIOE, 4'h1, TAG_RAM};

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/mio_addr_decode.sv
// Address tag decoder: compares the upper address nibble against
// every slot tag; the lowest matching slot index wins.
module mio_addr_decode
    import mio_bus_ctrl_pkg::*;
#(
    parameter int                         N_SLV    = 4,
    parameter logic [TAG_W*N_SLV-1:0]     SLV_TAGS = DEF_SLV_TAGS
) (
    input  logic [TAG_W-1:0] tag_i,
    output logic [N_SLV-1:0] onehot_o,
    output logic             hit_o
);

    always_comb begin
        onehot_o = '0;
        hit_o    = 1'b0;
        // Walk downwards so the lowest matching slot overwrites last.
        for (int i = N_SLV - 1; i >= 0; i--) begin
            if (tag_i == SLV_TAGS[TAG_W*i +: TAG_W]) begin
                onehot_o    = '0;
                onehot_o[i] = 1'b1;
                hit_o       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mio_bus_ctrl.sv
// Registered MIO bus controller: CPU req/ready handshake, slave
// select/ack handshake, access timeout and decode-miss error.
module mio_bus_ctrl
    import mio_bus_ctrl_pkg::*;
#(
    parameter int                     N_SLV    = 4,
    parameter int                     DW       = 32,
    parameter int                     AW       = 32,
    parameter logic [TAG_W*N_SLV-1:0] SLV_TAGS = DEF_SLV_TAGS,
    parameter int                     TIMEOUT  = 15,
    parameter logic [DW-1:0]          ERR_DATA = '0
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                cpu_req_i,
    input  logic                cpu_we_i,
    input  logic [AW-1:0]       cpu_addr_i,
    input  logic [DW-1:0]       cpu_wdata_i,
    input  logic [DW/8-1:0]     cpu_be_i,
    output logic                cpu_ready_o,
    output logic [DW-1:0]       cpu_rdata_o,
    output logic                cpu_err_o,
    output logic [N_SLV-1:0]    slv_sel_o,
    output logic                slv_we_o,
    output logic [AW-1:0]       slv_addr_o,
    output logic [DW-1:0]       slv_wdata_o,
    output logic [DW/8-1:0]     slv_be_o,
    input  logic [N_SLV*DW-1:0] slv_rdata_i,
    input  logic [N_SLV-1:0]    slv_ack_i,
    output logic [7:0]          err_count_o
);

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    logic [1:0]       state_q, state_d;
    logic [N_SLV-1:0] sel_q, sel_d;
    logic             we_q, we_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [DW-1:0]    wdata_q, wdata_d;
    logic [DW/8-1:0]  be_q, be_d;
    logic [7:0]       timer_q, timer_d;
    logic [DW-1:0]    rdata_q, rdata_d;
    logic             err_q, err_d;
    logic [7:0]       errcnt_q, errcnt_d;

    logic [N_SLV-1:0] dec_oh;
    logic             dec_hit;
    logic [DW-1:0]    rd_mux;
    logic             ack_sel;

    mio_addr_decode #(
        .N_SLV    (N_SLV),
        .SLV_TAGS (SLV_TAGS)
    ) u_dec (
        .tag_i    (cpu_addr_i[AW-1 -: TAG_W]),
        .onehot_o (dec_oh),
        .hit_o    (dec_hit)
    );

    // Only the selected slot's data and ack are ever looked at.
    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < N_SLV; i++) begin
            if (sel_q[i]) begin
                rd_mux = rd_mux | slv_rdata_i[i*DW +: DW];
            end
        end
    end

    assign ack_sel = |(slv_ack_i & sel_q);

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        be_d     = be_q;
        timer_d  = timer_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        errcnt_d = errcnt_q;
        case (state_q)
            S_IDLE: begin
                if (cpu_req_i) begin
                    we_d    = cpu_we_i;
                    addr_d  = cpu_addr_i;
                    wdata_d = cpu_wdata_i;
                    be_d    = cpu_be_i;
                    timer_d = 8'd0;
                    if (dec_hit) begin
                        state_d = S_ACCESS;
                        sel_d   = dec_oh;
                    end else begin
                        state_d  = S_RESP;
                        rdata_d  = ERR_DATA;
                        err_d    = 1'b1;
                        errcnt_d = sat_inc8(errcnt_q);
                    end
                end
            end
            S_ACCESS: begin
                if (ack_sel) begin
                    state_d = S_RESP;
                    sel_d   = '0;
                    rdata_d = we_q ? '0 : rd_mux;
                    err_d   = 1'b0;
                end else if (timer_q == TMO_LAST) begin
                    state_d  = S_RESP;
                    sel_d    = '0;
                    rdata_d  = ERR_DATA;
                    err_d    = 1'b1;
                    errcnt_d = sat_inc8(errcnt_q);
                end else begin
                    timer_d = timer_q + 8'd1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
                sel_d   = '0;
            end
            default: begin
                state_d = S_IDLE;
                sel_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= S_IDLE;
            sel_q    <= '0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            be_q     <= '0;
            timer_q  <= 8'd0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            errcnt_q <= 8'd0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            be_q     <= be_d;
            timer_q  <= timer_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
            errcnt_q <= errcnt_d;
        end
    end

    assign cpu_ready_o = (state_q == S_RESP);
    assign cpu_rdata_o = rdata_q;
    assign cpu_err_o   = err_q;
    assign slv_sel_o   = sel_q;
    assign slv_we_o    = we_q & (state_q == S_ACCESS);
    assign slv_addr_o  = addr_q;
    assign slv_wdata_o = wdata_q;
    assign slv_be_o    = be_q;
    assign err_count_o = errcnt_q;

endmodule

// File: tb/tb_mio_bus_ctrl.sv
// Bench for mio_bus_ctrl: directed scenarios plus randomized
// accesses checked against a transaction-level reference model.
module tb_mio_bus_ctrl;

    localparam int          TMO  = 15;
    localparam logic [31:0] ERRD = 32'hDEAD_BEEF;

    logic         clk_i = 1'b0;
    logic         rst_ni = 1'b0;
    logic         cpu_req_i = 1'b0;
    logic         cpu_we_i = 1'b0;
    logic [31:0]  cpu_addr_i = '0;
    logic [31:0]  cpu_wdata_i = '0;
    logic [3:0]   cpu_be_i = '0;
    logic         cpu_ready_o;
    logic [31:0]  cpu_rdata_o;
    logic         cpu_err_o;
    logic [3:0]   slv_sel_o;
    logic         slv_we_o;
    logic [31:0]  slv_addr_o;
    logic [31:0]  slv_wdata_o;
    logic [3:0]   slv_be_o;
    logic [127:0] slv_rdata_i = '0;
    logic [3:0]   slv_ack_i = '0;
    logic [7:0]   err_count_o;

    int n_cmp = 0;
    int n_err = 0;
    int exp_cnt = 0;
    int tags[4] = '{4'h0, 4'h1, 4'hE, 4'hF};

    always #5 clk_i = ~clk_i;

    mio_bus_ctrl #(
        .TIMEOUT  (TMO),
        .ERR_DATA (ERRD)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .cpu_req_i   (cpu_req_i),
        .cpu_we_i    (cpu_we_i),
        .cpu_addr_i  (cpu_addr_i),
        .cpu_wdata_i (cpu_wdata_i),
        .cpu_be_i    (cpu_be_i),
        .cpu_ready_o (cpu_ready_o),
        .cpu_rdata_o (cpu_rdata_o),
        .cpu_err_o   (cpu_err_o),
        .slv_sel_o   (slv_sel_o),
        .slv_we_o    (slv_we_o),
        .slv_addr_o  (slv_addr_o),
        .slv_wdata_o (slv_wdata_o),
        .slv_be_o    (slv_be_o),
        .slv_rdata_i (slv_rdata_i),
        .slv_ack_i   (slv_ack_i),
        .err_count_o (err_count_o)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One CPU access; entered and left at a negedge in an IDLE cycle.
    // dly = ACCESS cycles before the slave acks (>= TMO: never).
    task automatic xfer(input logic we, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [3:0] be,
                        input int dly, input bit spur,
                        input logic [31:0] rd);
        int          slot;
        int          nacc;
        int          cyc;
        bit          done;
        logic [31:0] rv[4];
        logic [31:0] erd;
        logic        eerr;
        logic [3:0]  oh;
        logic [3:0]  ackv;
        slot = -1;
        for (int i = 0; i < 4; i++)
            if (slot < 0 && tags[i] == int'(addr[31:28])) slot = i;
        for (int i = 0; i < 4; i++) rv[i] = $urandom;
        oh = 4'b0;
        if (slot >= 0) begin
            rv[slot] = rd;
            oh[slot] = 1'b1;
        end
        if (slot < 0) begin
            nacc = 0; eerr = 1'b1; erd = ERRD;
        end else if (dly < TMO) begin
            nacc = dly + 1; eerr = 1'b0; erd = we ? 32'h0 : rd;
        end else begin
            nacc = TMO; eerr = 1'b1; erd = ERRD;
        end
        if (eerr) exp_cnt = (exp_cnt >= 255) ? 255 : exp_cnt + 1;

        cpu_req_i   = 1'b1;
        cpu_we_i    = we;
        cpu_addr_i  = addr;
        cpu_wdata_i = wd;
        cpu_be_i    = be;
        slv_rdata_i = {rv[3], rv[2], rv[1], rv[0]};
        slv_ack_i   = spur ? 4'($urandom) & ~oh : 4'b0;
        cyc  = 0;
        done = 0;
        while (!done && cyc < 40) begin
            @(posedge clk_i);
            cyc++;
            #1;
            ackv = spur ? 4'($urandom) & ~oh : 4'b0;
            if (cyc <= nacc && cyc - 1 == dly) ackv = ackv | oh;
            slv_ack_i = ackv;
            @(negedge clk_i);
            if (cyc <= nacc) begin
                chk("acc_sel", 64'(slv_sel_o), 64'(oh));
                chk("acc_we", 64'(slv_we_o), 64'(we));
                chk("acc_be", 64'(slv_be_o), 64'(be));
                chk("acc_addr", 64'(slv_addr_o), 64'(addr));
                chk("acc_wdata", 64'(slv_wdata_o), 64'(wd));
                chk("acc_rdy", 64'(cpu_ready_o), 64'd0);
            end
            if (cpu_ready_o) begin
                done = 1;
                chk("latency", 64'(cyc), 64'(nacc + 1));
                chk("rdata", 64'(cpu_rdata_o), 64'(erd));
                chk("err", 64'(cpu_err_o), 64'(eerr));
                chk("errcnt", 64'(err_count_o), 64'(exp_cnt));
                chk("resp_sel", 64'(slv_sel_o), 64'd0);
            end
        end
        if (!done) chk("ready_seen", 64'd0, 64'd1);
        slv_ack_i = 4'b0;
        @(negedge clk_i);
        cpu_req_i = 1'b0;
        chk("rdy_pulse", 64'(cpu_ready_o), 64'd0);
        chk("rdata_hold", 64'(cpu_rdata_o), 64'(erd));
    endtask

    initial begin
        logic [31:0] a;
        logic [3:0]  t;
        time         t0;
        int          tsel;
        int          tagl[7] = '{0, 1, 14, 15, 7, 3, 9};

        #12;
        chk("rst_ready", 64'(cpu_ready_o), 64'd0);
        chk("rst_sel", 64'(slv_sel_o), 64'd0);
        chk("rst_errcnt", 64'(err_count_o), 64'd0);
        chk("rst_rdata", 64'(cpu_rdata_o), 64'd0);
        chk("rst_err", 64'(cpu_err_o), 64'd0);
        chk("rst_we", 64'(slv_we_o), 64'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);

        xfer(1'b0, 32'h0000_0010, 32'h0, 4'hF, 0, 1'b0, 32'h1234_5678);
        xfer(1'b1, 32'hF000_0004, 32'h0000_00A5, 4'b0001, 3, 1'b0, 32'h0);
        xfer(1'b0, 32'h7000_0000, 32'h0, 4'hF, 0, 1'b0, 32'h0);
        chk("miss_errcnt", 64'(err_count_o), 64'd1);
        xfer(1'b0, 32'hE000_0100, 32'h0, 4'hF, 1000, 1'b1, 32'h0);

        // Reset in the middle of an access.
        cpu_req_i  = 1'b1;
        cpu_we_i   = 1'b0;
        cpu_addr_i = 32'h1000_0020;
        repeat (3) @(posedge clk_i);
        #1;
        chk("pre_rst_sel", 64'(slv_sel_o), 64'h2);
        rst_ni = 1'b0;
        #1;
        chk("mid_rst_sel", 64'(slv_sel_o), 64'd0);
        chk("mid_rst_rdy", 64'(cpu_ready_o), 64'd0);
        chk("mid_rst_cnt", 64'(err_count_o), 64'd0);
        exp_cnt   = 0;
        cpu_req_i = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        xfer(1'b0, 32'h1000_0020, 32'h0, 4'hF, 1, 1'b0, 32'hCAFE_0001);

        for (int n = 0; n < 200; n++) begin
            tsel = int'($urandom_range(0, 6));
            t    = 4'(tagl[tsel]);
            a    = {t, 28'($urandom)};
            xfer(1'($urandom), a, $urandom, 4'($urandom),
                 int'($urandom_range(0, 20)), 1'($urandom), $urandom);
        end

        for (int n = 0; n < 260; n++) begin
            t0 = $time;
            xfer(1'b0, {4'h8, 28'($urandom)}, 32'h0, 4'hF, 0, 1'b0, 32'h0);
            if (n % 20 == 0) chk("b2b_period", 64'($time - t0), 64'd20);
        end
        chk("sat_errcnt", 64'(err_count_o), 64'hFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
